trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Machine-mode trap controller for the CSR/commit path. Arbitrates exceptions, MRET and the masked
//  interrupt lines, then sequences entry/return: flush and drain the pipeline, update the CSRs once,
//  and redirect fetch. One trap is in flight at a time.
// PARAMETERS
//  VECTORED_EN        1    1: honour mtvec MODE=01 (vectored) for interrupts; 0: always direct
//  MAX_DRAIN_CYCLES   255  FLUSH cycles allowed before drain_timeout is flagged (8-bit counter)
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   reset, asynchronous, active-low
//  exception_valid   in   1   synchronous exception pending at commit
//  exception_code    in   5   exception_code_t
//  exception_pc      in   32  PC of the faulting instruction
//  exception_tval    in   32  trap value
//  irq_pending       in   6   mip&mie: [0]SSI [1]MSI [2]STI [3]MTI [4]SEI [5]MEI
//  global_ie         in   1   mstatus.MIE
//  interrupt_pc      in   32  resume PC used when an interrupt is taken
//  mret_valid        in   1   MRET at commit
//  mtvec             in   32  current mtvec
//  mepc              in   32  current mepc
//  pipeline_drained  in   1   no instructions in flight
//  redirect_ready    in   1   fetch accepts redirect
//  trap_accept       out  1   1-cycle pulse: request captured
//  busy              out  1   FSM not IDLE
//  flush             out  1   pipeline flush request
//  csr_trap_we       out  1   write mepc/mcause/mtval, push mstatus MIE->MPIE
//  csr_mret_we       out  1   pop mstatus MPIE->MIE
//  csr_mepc          out  32  mepc write data
//  csr_mcause        out  32  mcause write data ({interrupt, 26'b0, code})
//  csr_mtval         out  32  mtval write data
//  redirect_valid    out  1   fetch redirect valid
//  redirect_pc       out  32  fetch redirect target
//  drain_timeout     out  1   sticky; set when FLUSH exceeds MAX_DRAIN_CYCLES
// BEHAVIOUR
//  - Reset: every output 0, state IDLE, drain counter 0. Async assertion mid-trap aborts the trap
//    (no CSR write, no redirect); drain_timeout clears only on reset.
//  - States: IDLE -> FLUSH -> UPDATE -> REDIRECT -> IDLE.
//  - IDLE selection, fixed priority: exception_valid > mret_valid > (global_ie & |irq_pending).
//    Selection registers kind/code/pc/tval, pulses trap_accept, enters FLUSH next cycle.
//    Inputs ignored while busy; requesters drop their request after trap_accept.
//  - Interrupt priority: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5); code latched at capture.
//  - FLUSH: flush=1; exit to UPDATE on the first cycle pipeline_drained=1 (may be the 1st FLUSH cycle).
//    Counter increments each FLUSH cycle, saturates; at count==MAX_DRAIN_CYCLES set drain_timeout,
//    keep waiting.
//  - UPDATE: exactly one cycle. Trap: csr_trap_we=1, csr_mepc = exception_pc or interrupt_pc,
//    csr_mcause = {is_irq,26'b0,code}, csr_mtval = tval (0 for interrupts). MRET: csr_mret_we=1.
//    redirect_pc is computed from mtvec/mepc sampled in this cycle.
//  - Target: exception -> {mtvec[31:2],2'b00}; interrupt with VECTORED_EN & mtvec[1:0]==01 ->
//    {mtvec[31:2],2'b00} + (code<<2), 32-bit wrap; else direct base; MRET -> {mepc[31:1],1'b0}.
//  - REDIRECT: redirect_valid=1 with stable redirect_pc until redirect_ready; handshake cycle
//    returns to IDLE. New request can be captured the cycle after.
//  - Min latency: capture c0, FLUSH c1 (drained), UPDATE c2, REDIRECT c3.
//  - csr_* data outputs hold their last value; only the strobes are meaningful.
// TESTING
//  1. exc ILLEGAL_INST(2), pc 0x100, tval 0x13, mtvec 0x8000_0000, drained at c1 -> c2
//     csr_trap_we, mcause 0x2, mepc 0x100, mtval 0x13; c3 redirect 0x8000_0000.
//  2. exception_valid + mret_valid + MEI in same cycle -> exception taken, mcause=exception code;
//     no mret write.
//  3. irq_pending 6'b101001 (MEI,MTI,SSI), global_ie=1, mtvec 0x8000_0001 -> mcause 0x8000_000B,
//     mtval 0, redirect 0x8000_002C; VECTORED_EN=0 -> 0x8000_0000.
//  4. irq_pending 6'b111111, global_ie=0 -> trap_accept/busy stay 0 for 20 cycles.
//  5. mret, mepc 0x205, redirect_ready low 3 cycles -> csr_mret_we 1 cycle, redirect_valid held
//     with pc 0x204 until ready.
//  6. drained low 300 cycles -> drain_timeout at 255th FLUSH cycle, flush held; rst_n low mid-FLUSH
//     -> outputs 0 immediately, no CSR write.

Source files
------------

// File: rtl/trap_if.sv
// Commit-side trap interface: requests, CSR state and pipeline status in; CSR strobes and redirect out.
// The master modport belongs to the commit/CSR logic. The slave modport belongs to trap_sequencer.
interface trap_if;
  logic        exception_valid;
  logic [4:0]  exception_code;
  logic [31:0] exception_pc;
  logic [31:0] exception_tval;
  logic [5:0]  irq_pending;
  logic        global_ie;
  logic [31:0] interrupt_pc;
  logic        mret_valid;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        pipeline_drained;
  logic        redirect_ready;

  logic        trap_accept;
  logic        busy;
  logic        flush;
  logic        csr_trap_we;
  logic        csr_mret_we;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mcause;
  logic [31:0] csr_mtval;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        drain_timeout;

  modport master (
    output exception_valid, exception_code, exception_pc, exception_tval,
           irq_pending, global_ie, interrupt_pc, mret_valid, mtvec, mepc,
           pipeline_drained, redirect_ready,
    input  trap_accept, busy, flush, csr_trap_we, csr_mret_we, csr_mepc,
           csr_mcause, csr_mtval, redirect_valid, redirect_pc, drain_timeout
  );

  modport slave (
    input  exception_valid, exception_code, exception_pc, exception_tval,
           irq_pending, global_ie, interrupt_pc, mret_valid, mtvec, mepc,
           pipeline_drained, redirect_ready,
    output trap_accept, busy, flush, csr_trap_we, csr_mret_we, csr_mepc,
           csr_mcause, csr_mtval, redirect_valid, redirect_pc, drain_timeout
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap controller: picks one exception, MRET or interrupt, then steps through
// flush, a single CSR update and a fetch redirect.
module trap_sequencer #(
  parameter bit          VECTORED_EN      = 1'b1,
  parameter int unsigned MAX_DRAIN_CYCLES = 255
) (
  input logic   clk,
  input logic   rst_n,
  trap_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_UPDATE, S_REDIRECT} state_t;
  typedef enum logic [1:0] {K_EXC, K_IRQ, K_MRET} kind_t;

  localparam logic [7:0] DRAIN_LIMIT = 8'(MAX_DRAIN_CYCLES);

  state_t      state_q, state_d;
  kind_t       kind_q, sel_kind;
  logic [4:0]  irq_code, code_q;
  logic        is_irq_q;
  logic [31:0] pc_q, tval_q, redirect_pc_q;
  logic        trap_accept_q;
  logic [7:0]  drain_cnt_q, drain_cnt_inc;
  logic        drain_timeout_q;
  logic        irq_req, take;
  logic [31:0] base, target;
  logic        flush, csr_trap_we, csr_mret_we, redirect_valid, busy;

  assign irq_req = bus.global_ie & (|bus.irq_pending);
  assign take    = (state_q == S_IDLE) & (bus.exception_valid | bus.mret_valid | irq_req);

  // NOTE: every signal written in an always_comb gets a default first, so that no path leaves
  // the signal unassigned and infers a latch.
  always_comb begin
    irq_code = 5'd5;
    if      (bus.irq_pending[5]) irq_code = 5'd11;
    else if (bus.irq_pending[1]) irq_code = 5'd3;
    else if (bus.irq_pending[3]) irq_code = 5'd7;
    else if (bus.irq_pending[4]) irq_code = 5'd9;
    else if (bus.irq_pending[0]) irq_code = 5'd1;

    sel_kind = K_IRQ;
    if      (bus.exception_valid) sel_kind = K_EXC;
    else if (bus.mret_valid)      sel_kind = K_MRET;
  end

  // Vector offset applies only to interrupts, and only in vectored mode (MODE=01).
  always_comb begin
    base   = bus.mtvec & 32'hFFFF_FFFC;
    target = base;
    if (kind_q == K_MRET)
      target = bus.mepc & 32'hFFFF_FFFE;
    else if (VECTORED_EN && (kind_q == K_IRQ) && (bus.mtvec[1:0] == 2'b01))
      target = base + {25'b0, code_q, 2'b00};
  end

  always_comb begin
    state_d        = state_q;
    flush          = 1'b0;
    csr_trap_we    = 1'b0;
    csr_mret_we    = 1'b0;
    redirect_valid = 1'b0;
    busy           = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:     if (take) state_d = S_FLUSH;
      S_FLUSH: begin
        flush = 1'b1;
        if (bus.pipeline_drained) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        csr_trap_we = (kind_q != K_MRET);
        csr_mret_we = (kind_q == K_MRET);
        state_d     = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (bus.redirect_ready) state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign drain_cnt_inc = (drain_cnt_q == 8'hFF) ? drain_cnt_q : drain_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q          <= K_EXC;
      code_q          <= '0;
      is_irq_q        <= 1'b0;
      pc_q            <= '0;
      tval_q          <= '0;
      trap_accept_q   <= 1'b0;
      redirect_pc_q   <= '0;
      drain_cnt_q     <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      trap_accept_q <= take;
      if (take) begin
        kind_q <= sel_kind;
        // An MRET leaves the trap data registers alone, so csr_* keep their last value.
        if (sel_kind != K_MRET) begin
          is_irq_q <= (sel_kind == K_IRQ);
          code_q   <= (sel_kind == K_IRQ) ? irq_code : bus.exception_code;
          pc_q     <= (sel_kind == K_IRQ) ? bus.interrupt_pc : bus.exception_pc;
          tval_q   <= (sel_kind == K_IRQ) ? 32'h0 : bus.exception_tval;
        end
      end
      if (state_q == S_FLUSH) begin
        drain_cnt_q <= drain_cnt_inc;
        if (drain_cnt_inc == DRAIN_LIMIT) drain_timeout_q <= 1'b1;
      end else begin
        drain_cnt_q <= '0;
      end
      if (state_q == S_UPDATE) redirect_pc_q <= target;
    end
  end

  assign bus.trap_accept    = trap_accept_q;
  assign bus.busy           = busy;
  assign bus.flush          = flush;
  assign bus.csr_trap_we    = csr_trap_we;
  assign bus.csr_mret_we    = csr_mret_we;
  assign bus.csr_mepc       = pc_q;
  assign bus.csr_mcause     = {is_irq_q, 26'b0, code_q};
  assign bus.csr_mtval      = tval_q;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.drain_timeout  = drain_timeout_q;
endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: a vectored and a direct instance see the same stimulus.
// Each request's expected CSR data and redirect target are queued when driven and checked on output.
module tb_trap_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_if tif ();
  trap_if dif ();

  assign dif.exception_valid  = tif.exception_valid;
  assign dif.exception_code   = tif.exception_code;
  assign dif.exception_pc     = tif.exception_pc;
  assign dif.exception_tval   = tif.exception_tval;
  assign dif.irq_pending      = tif.irq_pending;
  assign dif.global_ie        = tif.global_ie;
  assign dif.interrupt_pc     = tif.interrupt_pc;
  assign dif.mret_valid       = tif.mret_valid;
  assign dif.mtvec            = tif.mtvec;
  assign dif.mepc             = tif.mepc;
  assign dif.pipeline_drained = tif.pipeline_drained;
  assign dif.redirect_ready   = tif.redirect_ready;

  trap_sequencer #(.VECTORED_EN(1'b1), .MAX_DRAIN_CYCLES(255)) dut_v (.clk(clk), .rst_n(rst_n), .bus(tif));
  trap_sequencer #(.VECTORED_EN(1'b0), .MAX_DRAIN_CYCLES(255)) dut_d (.clk(clk), .rst_n(rst_n), .bus(dif));

  typedef struct packed {
    logic        is_mret;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] rpc_v;
    logic [31:0] rpc_d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] irq_code_of(input logic [5:0] p);
    if (p[5]) return 5'd11;
    if (p[1]) return 5'd3;
    if (p[3]) return 5'd7;
    if (p[4]) return 5'd9;
    if (p[0]) return 5'd1;
    return 5'd5;
  endfunction

  function automatic exp_t model(input logic exc, input logic [4:0] ecode,
                                 input logic [31:0] epc, input logic [31:0] etval,
                                 input logic mret, input logic [5:0] irq,
                                 input logic [31:0] ipc, input logic [31:0] mtvec,
                                 input logic [31:0] mepc);
    exp_t        e;
    logic [31:0] base;
    logic [4:0]  code;
    base = {mtvec[31:2], 2'b00};
    e    = '0;
    if (exc) begin
      e.mepc = epc; e.mcause = {27'b0, ecode}; e.mtval = etval;
      e.rpc_v = base; e.rpc_d = base;
    end else if (mret) begin
      e.is_mret = 1'b1;
      e.rpc_v = {mepc[31:1], 1'b0}; e.rpc_d = {mepc[31:1], 1'b0};
    end else begin
      code     = irq_code_of(irq);
      e.mepc   = ipc;
      e.mcause = 32'h8000_0000 | {27'b0, code};
      e.mtval  = 32'h0;
      e.rpc_d  = base;
      e.rpc_v  = (mtvec[1:0] == 2'b01) ? base + (32'(code) << 2) : base;
    end
    return e;
  endfunction

  // Output monitor: CSR data is checked against the head entry, which is retired at the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tif.csr_trap_we) begin
        if (sb.size() == 0 || sb[0].is_mret) check("unexpected_trap_we", 32'd1, 32'd0);
        else begin
          check("mepc",   tif.csr_mepc,   sb[0].mepc);
          check("mcause", tif.csr_mcause, sb[0].mcause);
          check("mtval",  tif.csr_mtval,  sb[0].mtval);
        end
      end
      if (tif.csr_mret_we) begin
        if (sb.size() == 0 || !sb[0].is_mret) check("unexpected_mret_we", 32'd1, 32'd0);
      end
      if (tif.redirect_valid && tif.redirect_ready) begin
        if (sb.size() == 0) check("unexpected_redirect", 32'd1, 32'd0);
        else begin
          check("redirect_pc_vectored", tif.redirect_pc, sb[0].rpc_v);
          check("redirect_pc_direct",   dif.redirect_pc, sb[0].rpc_d);
          void'(sb.pop_front());
          n_done++;
        end
      end
    end
  end

  task automatic issue(input logic exc, input logic [4:0] ecode, input logic [31:0] epc,
                       input logic [31:0] etval, input logic mret, input logic [5:0] irq);
    int lat;
    sb.push_back(model(exc, ecode, epc, etval, mret, irq, tif.interrupt_pc, tif.mtvec, tif.mepc));
    tif.exception_valid = exc;
    tif.exception_code  = ecode;
    tif.exception_pc    = epc;
    tif.exception_tval  = etval;
    tif.mret_valid      = mret;
    tif.irq_pending     = irq;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!tif.trap_accept && lat < 10);
    check("accept_latency", lat, 1);
    tif.exception_valid = 1'b0;
    tif.mret_valid      = 1'b0;
    tif.irq_pending     = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tif.busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_within_budget", tif.busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {tif.busy, tif.trap_accept, tif.flush, tif.csr_trap_we, tif.csr_mret_we,
                tif.redirect_valid, tif.drain_timeout}, 32'd0);
  endtask

  logic [5:0] irq_tab [6];

  initial begin
    irq_tab = '{6'b101001, 6'b011110, 6'b011100, 6'b010101, 6'b000101, 6'b000100};
    tif.exception_valid = 1'b0; tif.exception_code = '0; tif.exception_pc = '0;
    tif.exception_tval = '0; tif.irq_pending = '0; tif.global_ie = 1'b0;
    tif.interrupt_pc = '0; tif.mret_valid = 1'b0; tif.mtvec = '0; tif.mepc = '0;
    tif.pipeline_drained = 1'b0; tif.redirect_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    check("reset_redirect_pc", tif.redirect_pc, 32'h0);
    check("reset_mcause", tif.csr_mcause, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Illegal instruction at minimum latency.
    tif.mtvec = 32'h8000_0000; tif.pipeline_drained = 1'b1; tif.redirect_ready = 1'b1;
    issue(1'b1, 5'd2, 32'h100, 32'h13, 1'b0, 6'b0);
    check("c1_flush", tif.flush, 1'b1);
    @(posedge clk); #1;
    check("c1_accept_pulse", tif.trap_accept, 1'b0);
    check("c2_trap_we", tif.csr_trap_we, 1'b1);
    @(posedge clk); #1;
    check("c3_redirect_valid", tif.redirect_valid, 1'b1);
    check("c3_redirect_pc", tif.redirect_pc, 32'h8000_0000);
    wait_idle(20);

    // Exception wins over MRET and MEI; vectored mtvec does not apply to exceptions.
    tif.mtvec = 32'h8000_0001; tif.global_ie = 1'b1; tif.mepc = 32'h0000_0777;
    issue(1'b1, 5'd7, 32'h200, 32'hDEAD, 1'b1, 6'b100000);
    wait_idle(20);

    // Interrupt priority; tval input carries junk that must not reach mtval.
    tif.interrupt_pc = 32'h0000_0444;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 5'd0, 32'h0, 32'h55, 1'b0, irq_tab[i]);
      wait_idle(20);
    end
    tif.mtvec = 32'hFFFF_FFF1;
    issue(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 6'b100000);
    wait_idle(20);
    tif.mtvec = 32'h8000_0003;
    issue(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 6'b001000);
    wait_idle(20);

    // Masked interrupts are ignored until global_ie rises.
    tif.mtvec = 32'h8000_0001; tif.global_ie = 1'b0; tif.irq_pending = 6'b111111;
    repeat (20) begin
      @(posedge clk); #1;
      check("ie_off_idle", {tif.busy, tif.trap_accept}, 32'd0);
    end
    tif.global_ie = 1'b1;
    issue(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 6'b111111);
    wait_idle(20);
    tif.global_ie = 1'b0;

    // MRET with redirect backpressure.
    tif.mepc = 32'h0000_0205; tif.redirect_ready = 1'b0;
    issue(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 6'b0);
    @(posedge clk); #1;
    check("mret_we", tif.csr_mret_we, 1'b1);
    check("mret_no_trap_we", tif.csr_trap_we, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("mret_hold_valid", tif.redirect_valid, 1'b1);
      check("mret_hold_pc", tif.redirect_pc, 32'h0000_0204);
      check("mret_we_once", tif.csr_mret_we, 1'b0);
    end
    tif.redirect_ready = 1'b1;
    wait_idle(5);
    check("handshakes", n_done, 12);

    // Drain timeout, then reset mid-FLUSH aborts the trap.
    tif.mtvec = 32'h8000_0000; tif.pipeline_drained = 1'b0;
    issue(1'b1, 5'd5, 32'h300, 32'h0, 1'b0, 6'b0);
    repeat (249) @(posedge clk);
    #1;
    check("timeout_not_yet", tif.drain_timeout, 1'b0);
    check("flush_at_250", tif.flush, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("timeout_set", tif.drain_timeout, 1'b1);
    check("flush_held", tif.flush, 1'b1);
    repeat (40) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_outputs");
    sb.delete();
    repeat (2) @(posedge clk);
    tif.pipeline_drained = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_all_zero("after_abort_idle");
    check("scoreboard_empty", sb.size(), 32'd0);
    check("no_extra_handshake", n_done, 12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end
endmodule
